// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the multi-cycle ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_NOT  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_EQ   = 4'd8,
    ALU_SLL  = 4'd9,
    ALU_SRL  = 4'd10,
    ALU_SRA  = 4'd11,
    ALU_MUL  = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] ALU_OP_ILLEGAL_MIN = 4'd13;

  function automatic logic is_illegal(input logic [3:0] op);
    return op >= ALU_OP_ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier: one multiplier bit per cycle, low W bits of the product.
module alu_mul_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_next;
  logic [CW-1:0] cnt;

  assign acc_next = mplier[0] ? acc + mcand : acc;
  assign busy     = (cnt != '0);
  // Product is taken from the final step's sum so the top can register it on the same edge.
  assign done     = (cnt == CW'(1));
  assign product  = acc_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(W);
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready request port and registered, back-pressured response.
//   state  | meaning
//   S_IDLE | waiting for a request
//   S_BUSY | iterative multiply in progress
//   S_DONE | response held until out_ready
module alu_mc
  import alu_pkg::*;
#(
  parameter int W  = 32,
  parameter int SW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         overflow,
  output logic         carry
);

  state_e       state;
  logic         accept;
  logic         mul_start;
  logic         mul_busy;
  logic         mul_done;
  logic [W-1:0] mul_product;

  logic [W-1:0] alu_res;
  logic         alu_ovf;
  logic         alu_cy;
  logic [W:0]   sum;
  logic [W:0]   diff;
  logic [SW-1:0] sh;

  assign out_valid = (state == S_DONE);
  assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == ALU_MUL);

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
  assign sh   = b[SW-1:0];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_cy  = 1'b0;
    if (!is_illegal(op)) begin
      case (op)
        ALU_ADD: begin
          alu_res = sum[W-1:0];
          alu_cy  = sum[W];
          alu_ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
        end
        ALU_SUB: begin
          alu_res = diff[W-1:0];
          alu_cy  = diff[W];
          alu_ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
        end
        ALU_NOT:  alu_res = ~a;
        ALU_AND:  alu_res = a & b;
        ALU_OR:   alu_res = a | b;
        ALU_XOR:  alu_res = a ^ b;
        ALU_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
        ALU_SLTU: alu_res = {{(W-1){1'b0}}, (a < b)};
        ALU_EQ:   alu_res = {{(W-1){1'b0}}, (a == b)};
        ALU_SLL:  alu_res = a << sh;
        ALU_SRL:  alu_res = a >> sh;
        ALU_SRA:  alu_res = $signed(a) >>> sh;
        default:  alu_res = '0;
      endcase
    end
  end

  alu_mul_iter #(.W(W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      carry    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // In DONE with out_ready low nothing moves, so the response holds.
          if ((state == S_IDLE) || out_ready) begin
            if (accept && (op == ALU_MUL)) begin
              state <= S_BUSY;
            end else if (accept) begin
              state    <= S_DONE;
              result   <= alu_res;
              zero     <= (alu_res == '0);
              overflow <= alu_ovf;
              carry    <= alu_cy;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_BUSY: begin
          if (mul_busy && mul_done) begin
            state    <= S_DONE;
            result   <= mul_product;
            zero     <= (mul_product == '0);
            overflow <= 1'b0;
            carry    <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
